// File: rtl/axi_pkg.sv
// Shared constants, FSM state types and the address-range helper for the AXI slave memory.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam int         MAX_BEATS   = 16;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    // A word address is usable only at or above the base and below base + depth words.
    function automatic logic addrInRange(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
        logic [31:0] offset;
        offset = addr - base;
        return (addr >= base) && ((offset >> 2) < depth);
    endfunction

endpackage

// File: rtl/axi_slave_mem_array.sv
// DEPTH x 32-bit word storage: one byte-enabled synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module axi_slave_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wbe_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI-style word-addressed SRAM slave with independent write and read FSMs.
// Define AXI_SLV_BYTE_STRB_EN to add the WSTRB_i byte-lane write enables.
module axi_slave_mem #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h1010_1000,
    parameter int          ID_W      = 4
) (
    input  logic            ACLK_i,
    input  logic            ARESET_i,
    input  logic [31:0]     AWADDR_i,
    input  logic            AWVALID_i,
    input  logic [ID_W-1:0] AWID_i,
    output logic            AWREADY_o,
    input  logic [31:0]     WDATA_i,
    input  logic            WVALID_i,
    input  logic [3:0]      WLEN_i,
    input  logic [2:0]      WSIZE_i,
    input  logic            WLAST_i,
`ifdef AXI_SLV_BYTE_STRB_EN
    input  logic [3:0]      WSTRB_i,
`endif
    output logic            WREADY_o,
    output logic [1:0]      BRESP_o,
    output logic            BVALID_o,
    output logic [ID_W-1:0] BID_o,
    input  logic            BREADY_i,
    input  logic [31:0]     ARADDR_i,
    input  logic            ARVALID_i,
    input  logic [ID_W-1:0] ARID_i,
    input  logic [3:0]      ARLEN_i,
    output logic            ARREADY_o,
    output logic [31:0]     RDATA_o,
    output logic            RVALID_o,
    output logic            RLAST_o,
    output logic [1:0]      RRESP_o,
    output logic [ID_W-1:0] RID_o,
    output logic [3:0]      RLEN_o,
    output logic [2:0]      RSIZE_o,
    input  logic            RREADY_i
);
    import axi_pkg::*;

    localparam int AW = $clog2(DEPTH);

    wstate_e         wstate_q, wstate_d;
    logic [31:0]     waddr_q, waddr_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic            werr_q, werr_d;
    logic [3:0]      wbeat_q, wbeat_d;
    logic            wBeatOk, memWe;
    logic [3:0]      memBe;
    logic [AW-1:0]   wIdx, rIdx;

    rstate_e         rstate_q, rstate_d;
    logic [31:0]     raddr_q, raddr_d, rLoadAddr;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [3:0]      rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [31:0]     rdata_q, rdata_d, memRdata;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d, rLoad;

    logic            unusedBits;

`ifdef AXI_SLV_BYTE_STRB_EN
    assign memBe = WSTRB_i;
`else
    assign memBe = 4'hF;
`endif

    assign wBeatOk    = addrInRange(waddr_q, BASE_ADDR, 32'(DEPTH)) && (WSIZE_i == SIZE_4B);
    assign wIdx       = AW'((waddr_q - BASE_ADDR) >> 2);
    assign rLoadAddr  = (rstate_q == R_IDLE) ? ARADDR_i : raddr_q + 32'd4;
    assign rIdx       = AW'((rLoadAddr - BASE_ADDR) >> 2);
    assign unusedBits = ^{WLEN_i, wbeat_q};

    axi_slave_mem_array #(.DEPTH(DEPTH), .AW(AW)) uArray (
        .clk_i   (ACLK_i),
        .we_i    (memWe),
        .waddr_i (wIdx),
        .wdata_i (WDATA_i),
        .wbe_i   (memBe),
        .raddr_i (rIdx),
        .rdata_o (memRdata)
    );

    // Write path: address phase, data beats with a sticky error, then a held B response.
    always_comb begin
        wstate_d  = wstate_q;
        waddr_d   = waddr_q;
        bid_d     = bid_q;
        werr_d    = werr_q;
        wbeat_d   = wbeat_q;
        memWe     = 1'b0;
        AWREADY_o = 1'b0;
        WREADY_o  = 1'b0;
        BVALID_o  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                AWREADY_o = 1'b1;
                if (AWVALID_i) begin
                    waddr_d  = AWADDR_i;
                    bid_d    = AWID_i;
                    wbeat_d  = '0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                WREADY_o = 1'b1;
                if (WVALID_i) begin
                    memWe   = wBeatOk;
                    werr_d  = werr_q | ~wBeatOk;
                    waddr_d = waddr_q + 32'd4;
                    if (wbeat_q != 4'(MAX_BEATS - 1)) wbeat_d = wbeat_q + 4'd1;
                    if (WLAST_i) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                BVALID_o = 1'b1;
                if (BREADY_i) begin
                    werr_d   = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign BRESP_o = (wstate_q == W_RESP && werr_q) ? RESP_SLVERR : RESP_OKAY;
    assign BID_o   = (wstate_q == W_RESP) ? bid_q : '0;

    // Read path: the output registers always hold the beat on offer; the next beat is
    // loaded on each non-last handshake, so memory is sampled before any same-edge write.
    always_comb begin
        rstate_d  = rstate_q;
        raddr_d   = raddr_q;
        rid_d     = rid_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rLoad     = 1'b0;
        ARREADY_o = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                ARREADY_o = 1'b1;
                if (ARVALID_i) begin
                    rLoad    = 1'b1;
                    raddr_d  = ARADDR_i;
                    rid_d    = ARID_i;
                    rlen_d   = ARLEN_i;
                    rbeat_d  = '0;
                    rlast_d  = (ARLEN_i == 4'd0);
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY_i) begin
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rLoad   = 1'b1;
                        raddr_d = rLoadAddr;
                        rbeat_d = rbeat_q + 4'd1;
                        rlast_d = ((rbeat_q + 4'd1) == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        if (rLoad) begin
            if (addrInRange(rLoadAddr, BASE_ADDR, 32'(DEPTH))) begin
                rdata_d = memRdata;
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    assign RVALID_o = (rstate_q == R_DATA);
    assign RDATA_o  = rdata_q;
    assign RRESP_o  = rresp_q;
    assign RLAST_o  = rlast_q;
    assign RID_o    = rid_q;
    assign RLEN_o   = rlen_q;
    assign RSIZE_o  = SIZE_4B;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            bid_q    <= '0;
            werr_q   <= 1'b0;
            wbeat_q  <= '0;
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rid_q    <= '0;
            rlen_q   <= '0;
            rbeat_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            bid_q    <= bid_d;
            werr_q   <= werr_d;
            wbeat_q  <= wbeat_d;
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rid_q    <= rid_d;
            rlen_q   <= rlen_d;
            rbeat_q  <= rbeat_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: table-driven bursts, scoreboarded B/R channels
// and hand-written backpressure, collision and mid-burst reset sequences.
module tb_axi_slave_mem;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h1010_1000;
    localparam int          ID_W  = 4;

    logic            aclk = 1'b0;
    logic            areset;
    logic [31:0]     awaddr, wdata, araddr;
    logic            awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [ID_W-1:0] awid, arid;
    logic [3:0]      wlen, arlen;
    logic [2:0]      wsize;
`ifdef AXI_SLV_BYTE_STRB_EN
    logic [3:0]      wstrb;
`endif
    logic            awready, wready, bvalid, arready, rvalid, rlast;
    logic [1:0]      bresp, rresp;
    logic [ID_W-1:0] bid, rid;
    logic [31:0]     rdata;
    logic [3:0]      rlen;
    logic [2:0]      rsize;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct packed {
        logic            isWrite;
        logic [31:0]     addr;
        logic [3:0]      id;
        logic [4:0]      nBeats;
        logic [3:0][31:0] data;
        logic [2:0]      size;
        logic [1:0]      expResp;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  len;
    } rexp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rexp_t       rQ[$];
    bexp_t       bQ[$];
    logic [31:0] model [int];
    vec_t        vecs [12];

    axi_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ID_W(ID_W)) dut (
        .ACLK_i    (aclk),
        .ARESET_i  (areset),
        .AWADDR_i  (awaddr),
        .AWVALID_i (awvalid),
        .AWID_i    (awid),
        .AWREADY_o (awready),
        .WDATA_i   (wdata),
        .WVALID_i  (wvalid),
        .WLEN_i    (wlen),
        .WSIZE_i   (wsize),
        .WLAST_i   (wlast),
`ifdef AXI_SLV_BYTE_STRB_EN
        .WSTRB_i   (wstrb),
`endif
        .WREADY_o  (wready),
        .BRESP_o   (bresp),
        .BVALID_o  (bvalid),
        .BID_o     (bid),
        .BREADY_i  (bready),
        .ARADDR_i  (araddr),
        .ARVALID_i (arvalid),
        .ARID_i    (arid),
        .ARLEN_i   (arlen),
        .ARREADY_o (arready),
        .RDATA_o   (rdata),
        .RVALID_o  (rvalid),
        .RLAST_o   (rlast),
        .RRESP_o   (rresp),
        .RID_o     (rid),
        .RLEN_o    (rlen),
        .RSIZE_o   (rsize),
        .RREADY_i  (rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic inRange(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic timeoutFail(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: actual=timeout required=handshake", name);
    endtask

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] old;
        old = model.exists(idxOf(a)) ? model[idxOf(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) old[8*b +: 8] = d[8*b +: 8];
        model[idxOf(a)] = old;
    endtask

    // Channel monitor: pops scoreboard entries on B/R handshakes and checks stall stability.
    logic  rStallSeen = 1'b0;
    rexp_t rStallSnap;
    logic  bStallSeen = 1'b0;
    bexp_t bStallSnap;

    task automatic monitorStep();
        rexp_t cur, exp;
        bexp_t bcur, bexp;
        cur  = '{data: rdata, resp: rresp, last: rlast, id: rid, len: rlen};
        bcur = '{resp: bresp, id: bid};
        if (rvalid && rStallSeen) begin
            checkOutput("rStableData", cur.data, rStallSnap.data);
            checkOutput("rStableCtl", 32'({cur.resp, cur.last, cur.id, cur.len}),
                        32'({rStallSnap.resp, rStallSnap.last, rStallSnap.id, rStallSnap.len}));
        end
        if (bvalid && bStallSeen) checkOutput("bStable", 32'(bcur), 32'(bStallSnap));
        if (rvalid && rready) begin
            if (rQ.size() == 0) begin
                checkOutput("rUnexpectedBeat", rdata, 32'hxxxxxxxx);
            end else begin
                exp = rQ.pop_front();
                checkOutput("rData", rdata, exp.data);
                checkOutput("rResp", 32'(rresp), 32'(exp.resp));
                checkOutput("rLast", 32'(rlast), 32'(exp.last));
                checkOutput("rId", 32'(rid), 32'(exp.id));
                checkOutput("rLen", 32'(rlen), 32'(exp.len));
                checkOutput("rSize", 32'(rsize), 32'd2);
            end
        end
        if (bvalid && bready) begin
            if (bQ.size() == 0) begin
                checkOutput("bUnexpected", 32'(bcur), 32'hxxxxxxxx);
            end else begin
                bexp = bQ.pop_front();
                checkOutput("bResp", 32'(bresp), 32'(bexp.resp));
                checkOutput("bId", 32'(bid), 32'(bexp.id));
            end
        end
        rStallSeen = rvalid && !rready;
        rStallSnap = cur;
        bStallSeen = bvalid && !bready;
        bStallSnap = bcur;
    endtask

    always @(negedge aclk) monitorStep();

    task automatic awHandshake(input logic [31:0] addr, input logic [3:0] id);
        int cnt;
        awaddr = addr; awid = id; awvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
        if (!awready) timeoutFail("awHandshake");
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [3:0] id, input int n,
                              input logic [3:0][31:0] data, input logic [2:0] size,
                              input logic [3:0] strb, input logic [1:0] expResp, input int bDelay);
        int cnt;
        logic [31:0] a;
        awHandshake(addr, id);
        for (int k = 0; k < n; k++) begin
            wdata = data[k]; wsize = size; wlast = (k == n - 1); wvalid = 1'b1; wlen = 4'(n - 1);
`ifdef AXI_SLV_BYTE_STRB_EN
            wstrb = strb;
`endif
            cnt = 0;
            while (!wready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
            if (!wready) timeoutFail("wReady");
            a = addr + 32'(4 * k);
            if (inRange(a) && size == 3'b010) modelWrite(a, data[k], strb);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bQ.push_back('{resp: expResp, id: id});
        for (int c = 0; c < bDelay; c++) begin
            checkOutput("bHeldValid", 32'(bvalid), 32'd1);
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        cnt = 0;
        while (!bvalid && cnt < 50) begin @(posedge aclk); #1; cnt++; end
        if (!bvalid) timeoutFail("bValid");
        @(posedge aclk); #1;
        bready = 1'b0;
        checkOutput("bDoneValid", 32'(bvalid), 32'd0);
        checkOutput("bDoneAwready", 32'(awready), 32'd1);
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len, input logic toggle);
        int cnt;
        logic [31:0] a;
        for (int k = 0; k <= int'(len); k++) begin
            a = addr + 32'(4 * k);
            rQ.push_back('{data: inRange(a) ? model[idxOf(a)] : 32'h0,
                           resp: inRange(a) ? 2'b00 : 2'b10,
                           last: (k == int'(len)), id: id, len: len});
        end
        araddr = addr; arid = id; arlen = len; arvalid = 1'b1;
        cnt = 0;
        while (!arready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
        if (!arready) timeoutFail("arHandshake");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        cnt = 0;
        while (rQ.size() > 0 && cnt < 100) begin
            rready = toggle ? (cnt % 2 == 0) : 1'b1;
            @(posedge aclk); #1;
            cnt++;
        end
        rready = 1'b0;
        if (rQ.size() > 0) begin
            timeoutFail("rBurstIncomplete");
            rQ.delete();
        end
        checkOutput("rDoneValid", 32'(rvalid), 32'd0);
        checkOutput("rDoneArready", 32'(arready), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isWrite) writeBurst(v.addr, v.id, int'(v.nBeats), v.data, v.size, 4'hF, v.expResp, 0);
        else           readBurst(v.addr, v.id, 4'(v.nBeats - 5'd1), 1'b0);
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; awid = '0;
        wdata = '0; wvalid = 1'b0; wlen = '0; wsize = 3'b010; wlast = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0; rready = 1'b0;
`ifdef AXI_SLV_BYTE_STRB_EN
        wstrb = 4'hF;
`endif
        vecs[0]  = '{1'b1, 32'h1010_1010, 4'd4,  5'd4,
                     {32'hABCDEF77, 32'hABCDEF6C, 32'h0EFDAB8C, 32'h7FEABAAC}, 3'b010, 2'b00};
        vecs[1]  = '{1'b0, 32'h1010_1010, 4'd2,  5'd4, 128'h0, 3'b010, 2'b00};
        vecs[2]  = '{1'b1, 32'hBCED_F123, 4'd1,  5'd1, {96'h0, 32'hDEADBEEF}, 3'b010, 2'b10};
        vecs[3]  = '{1'b0, 32'hBCED_F123, 4'd7,  5'd1, 128'h0, 3'b010, 2'b00};
        vecs[4]  = '{1'b1, 32'h1010_1000, 4'd5,  5'd2, {64'h0, 32'h5A5A5A5A, 32'hA5A5A5A5}, 3'b010, 2'b00};
        vecs[5]  = '{1'b1, 32'h1010_13FC, 4'd3,  5'd2, {64'h0, 32'h33334444, 32'h11112222}, 3'b010, 2'b10};
        vecs[6]  = '{1'b0, 32'h1010_13FC, 4'd9,  5'd2, 128'h0, 3'b010, 2'b00};
        vecs[7]  = '{1'b1, 32'h1010_1000, 4'd15, 5'd1, {96'h0, 32'hCAFEF00D}, 3'b011, 2'b10};
        vecs[8]  = '{1'b1, 32'h1010_0FFC, 4'd8,  5'd2, {64'h0, 32'h02020202, 32'h01010101}, 3'b010, 2'b10};
        vecs[9]  = '{1'b0, 32'h1010_0FFC, 4'd10, 5'd2, 128'h0, 3'b010, 2'b00};
        vecs[10] = '{1'b0, 32'h1010_1000, 4'd12, 5'd2, 128'h0, 3'b010, 2'b00};
        vecs[11] = '{1'b1, 32'h1010_1020, 4'd6,  5'd1, {96'h0, 32'h0BADF00D}, 3'b010, 2'b00};

        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        checkOutput("rstAwready", 32'(awready), 32'd1);
        checkOutput("rstArready", 32'(arready), 32'd1);
        checkOutput("rstWready",  32'(wready),  32'd0);
        checkOutput("rstBvalid",  32'(bvalid),  32'd0);
        checkOutput("rstRvalid",  32'(rvalid),  32'd0);
        checkOutput("rstRlast",   32'(rlast),   32'd0);
        checkOutput("rstRdata",   rdata,        32'd0);
        checkOutput("rstIds",     32'({bid, rid, rlen, bresp, rresp}), 32'd0);
        checkOutput("rstRsize",   32'(rsize),   32'd2);

        wvalid = 1'b1; wdata = 32'h5555AAAA; wlast = 1'b1;
        @(posedge aclk); #1;
        checkOutput("wStallBeforeAw", 32'(wready), 32'd0);
        wvalid = 1'b0; wlast = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        $display("[TB] backpressure sequence");
        writeBurst(32'h1010_1080, 4'd10, 1, {96'h0, 32'h600DCAFE}, 3'b010, 4'hF, 2'b00, 5);
        readBurst(32'h1010_1010, 4'd3, 4'd3, 1'b1);

        $display("[TB] collision sequence");
        awHandshake(32'h1010_1020, 4'd11);
        rQ.push_back('{data: model[idxOf(32'h1010_1020)], resp: 2'b00, last: 1'b1, id: 4'd13, len: 4'd0});
        wdata = 32'hFEEDFACE; wvalid = 1'b1; wlast = 1'b1; wsize = 3'b010;
`ifdef AXI_SLV_BYTE_STRB_EN
        wstrb = 4'hF;
`endif
        araddr = 32'h1010_1020; arid = 4'd13; arlen = 4'd0; arvalid = 1'b1;
        checkOutput("collWready", 32'(wready), 32'd1);
        checkOutput("collArready", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        modelWrite(32'h1010_1020, 32'hFEEDFACE, 4'hF);
        bQ.push_back('{resp: 2'b00, id: 4'd11});
        bready = 1'b1; rready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0; rready = 1'b0;
        checkOutput("collRPending", 32'(rQ.size()), 32'd0);
        checkOutput("collBPending", 32'(bQ.size()), 32'd0);
        readBurst(32'h1010_1020, 4'd14, 4'd0, 1'b0);

        $display("[TB] reset mid-burst sequence");
        awHandshake(32'h1010_1040, 4'd6);
        wdata = 32'h01020304; wvalid = 1'b1; wlast = 1'b0; wsize = 3'b010;
        @(posedge aclk); #1;
        modelWrite(32'h1010_1040, 32'h01020304, 4'hF);
        wdata = 32'h05060708;
        @(posedge aclk); #1;
        modelWrite(32'h1010_1044, 32'h05060708, 4'hF);
        wvalid = 1'b0; areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        checkOutput("midRstAwready", 32'(awready), 32'd1);
        checkOutput("midRstBvalid",  32'(bvalid),  32'd0);
        checkOutput("midRstWready",  32'(wready),  32'd0);
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("midRstNoB", 32'(bvalid), 32'd0);
        readBurst(32'h1010_1040, 4'd2, 4'd1, 1'b0);

`ifdef AXI_SLV_BYTE_STRB_EN
        $display("[TB] byte strobe sequence");
        writeBurst(32'h1010_10A0, 4'd1, 1, {96'h0, 32'h12345678}, 3'b010, 4'hF, 2'b00, 0);
        writeBurst(32'h1010_10A0, 4'd2, 1, {96'h0, 32'hFFFFFFFF}, 3'b010, 4'b0011, 2'b00, 0);
        writeBurst(32'h1010_10A0, 4'd3, 1, {96'h0, 32'h0BAD0BAD}, 3'b010, 4'b0000, 2'b00, 0);
        rQ.push_back('{data: 32'h1234FFFF, resp: 2'b00, last: 1'b1, id: 4'd4, len: 4'd0});
        araddr = 32'h1010_10A0; arid = 4'd4; arlen = 4'd0; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        checkOutput("strbRPending", 32'(rQ.size()), 32'd0);
`endif

        repeat (2) @(posedge aclk);
        #1;
        checkOutput("endRQueue", 32'(rQ.size()), 32'd0);
        checkOutput("endBQueue", 32'(bQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
